// File: rtl/vga_pixel_fetch_if.sv
// Raster/ROM/pixel bundle for vga_pixel_fetch.
// The timing controller and ROM side drive it as master; the fetch block is the slave.
interface vga_pixel_fetch_if;
   logic        pix_en;
   logic [9:0]  x;
   logic [9:0]  y;
   logic        hsync_in;
   logic        vsync_in;
   logic        blank_b_in;
   logic [23:0] rom_addr;
   logic [23:0] rom_data;
   logic        hsync;
   logic        vsync;
   logic        blank_b;
   logic [7:0]  r;
   logic [7:0]  g;
   logic [7:0]  b;
   logic        frame_done;

   modport master (
      output pix_en, x, y, hsync_in, vsync_in, blank_b_in, rom_data,
      input  rom_addr, hsync, vsync, blank_b, r, g, b, frame_done
   );

   modport slave (
      input  pix_en, x, y, hsync_in, vsync_in, blank_b_in, rom_data,
      output rom_addr, hsync, vsync, blank_b, r, g, b, frame_done
   );
endinterface

// File: rtl/vga_pixel_fetch.sv
// Two-stage image fetch for a VGA raster.
// Stage 1 issues the ROM word address for the current raster position.
// Stage 2 turns the returned ROM word into rgb, with the syncs delayed to match.
// Addressing is counter based: row_base advances by IMG_W per replicated row,
// and col advances once per SCALE pixels.
module vga_pixel_fetch #(
   parameter logic [9:0] LEFT  = 10'd0,
   parameter logic [9:0] TOP   = 10'd0,
   parameter int         IMG_W = 180,
   parameter int         IMG_H = 180,
   parameter int         SCALE = 1
) (
   input  logic             clk,
   input  logic             reset,
   vga_pixel_fetch_if.slave bus
);

   typedef enum logic {WAIT_FRAME, ACTIVE} state_t;

   localparam logic [11:0] X_SPAN    = 12'(IMG_W * SCALE);
   localparam logic [11:0] Y_SPAN    = 12'(IMG_H * SCALE);
   localparam logic [23:0] W24       = 24'(IMG_W);
   localparam logic [23:0] LAST_ADDR = 24'(IMG_W * IMG_H - 1);
   localparam logic        SREP      = (SCALE == 2);

   state_t      state_q, state_d;
   logic [23:0] rom_addr_q, rom_addr_d;
   logic [23:0] col_q, col_d, col_c;
   logic [23:0] row_base_q, row_base_d, row_c;
   logic        xrep_q, xrep_d, xrep_c;
   logic        yrep_q, yrep_d, yrep_c;
   logic [11:0] xoff, yoff;
   logic        frame_start, in_win, last_col, fd_d;
   logic        in_win_q, hs1_q, vs1_q, bl1_q;
   logic        hs2_q, vs2_q, bl2_q, frame_done_q;
   logic [7:0]  r_q, g_q, b_q, r_d, g_d, b_d;

   // Offsets wrap to a large value left of / above the window, so one compare each suffices
   assign xoff        = {2'b00, bus.x} - {2'b00, LEFT};
   assign yoff        = {2'b00, bus.y} - {2'b00, TOP};
   assign frame_start = bus.pix_en && (bus.x == '0) && (bus.y == '0);
   assign in_win      = ((state_q == ACTIVE) || frame_start) && (xoff < X_SPAN) && (yoff < Y_SPAN);
   assign last_col    = (xoff == X_SPAN - 12'd1);

   // Next state: leave WAIT_FRAME at the first frame start; only reset returns there
   always_comb begin
      state_d = state_q;
      if (state_q == WAIT_FRAME && frame_start) state_d = ACTIVE;
   end

   // Address counters; line/frame clears are folded in first so the current pixel sees them
   always_comb begin
      col_c      = (bus.x == LEFT) ? '0 : col_q;
      xrep_c     = (bus.x == LEFT) ? 1'b0 : xrep_q;
      row_c      = frame_start ? '0 : row_base_q;
      yrep_c     = frame_start ? 1'b0 : yrep_q;
      col_d      = col_c;
      xrep_d     = xrep_c;
      row_base_d = row_c;
      yrep_d     = yrep_c;
      rom_addr_d = rom_addr_q;
      fd_d       = 1'b0;
      if (in_win) begin
         rom_addr_d = row_c + col_c;
         if (xrep_c == SREP) begin
            xrep_d = 1'b0;
            col_d  = col_c + 24'd1;
         end else begin
            xrep_d = xrep_c + 1'b1;
         end
         if (last_col) begin
            if (yrep_c == SREP) begin
               yrep_d     = 1'b0;
               row_base_d = row_c + W24;
            end else begin
               yrep_d = yrep_c + 1'b1;
            end
            fd_d = (yoff == Y_SPAN - 12'd1) && (rom_addr_d == LAST_ADDR);
         end
      end
   end

   // Colour select: black outside the window or during blanking
   always_comb begin
      r_d = '0;
      g_d = '0;
      b_d = '0;
      if (in_win_q && bl1_q) begin
         r_d = bus.rom_data[7:0];
         g_d = bus.rom_data[15:8];
         b_d = bus.rom_data[23:16];
      end
   end

   // State, counters and stage 1 registers advance only on pix_en
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= WAIT_FRAME;
         rom_addr_q <= '0;
         col_q      <= '0;
         row_base_q <= '0;
         xrep_q     <= 1'b0;
         yrep_q     <= 1'b0;
         in_win_q   <= 1'b0;
         hs1_q      <= 1'b1;
         vs1_q      <= 1'b1;
         bl1_q      <= 1'b0;
      end else if (bus.pix_en) begin
         state_q    <= state_d;
         rom_addr_q <= rom_addr_d;
         col_q      <= col_d;
         row_base_q <= row_base_d;
         xrep_q     <= xrep_d;
         yrep_q     <= yrep_d;
         in_win_q   <= in_win;
         hs1_q      <= bus.hsync_in;
         vs1_q      <= bus.vsync_in;
         bl1_q      <= bus.blank_b_in;
      end
   end

   // Stage 2: rgb and the timing signals delayed one more pix_en
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_q   <= '0;
         g_q   <= '0;
         b_q   <= '0;
         hs2_q <= 1'b1;
         vs2_q <= 1'b1;
         bl2_q <= 1'b0;
      end else if (bus.pix_en) begin
         r_q   <= r_d;
         g_q   <= g_d;
         b_q   <= b_d;
         hs2_q <= hs1_q;
         vs2_q <= vs1_q;
         bl2_q <= bl1_q;
      end
   end

   // frame_done is cleared on non-pix_en edges so it stays a single-clk pulse
   always_ff @(posedge clk or posedge reset) begin
      if (reset) frame_done_q <= 1'b0;
      else       frame_done_q <= bus.pix_en && fd_d;
   end

   assign bus.rom_addr   = rom_addr_q;
   assign bus.hsync      = hs2_q;
   assign bus.vsync      = vs2_q;
   assign bus.blank_b    = bl2_q;
   assign bus.r          = r_q;
   assign bus.g          = g_q;
   assign bus.b          = b_q;
   assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Bench for vga_pixel_fetch: a default instance and a SCALE=2 instance share one raster.
// Expected addresses come from the closed-form (y-TOP)/SCALE*IMG_W + (x-LEFT)/SCALE.
module tb_vga_pixel_fetch;
   logic clk = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;
   int   fd_cnt = 0;

   always #5 clk = ~clk;

   vga_pixel_fetch_if bus1 ();
   vga_pixel_fetch_if bus2 ();

   vga_pixel_fetch dut1 (.clk(clk), .reset(reset), .bus(bus1));
   vga_pixel_fetch #(.SCALE(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

   // ROM contents: address 365 holds the reference colour, everything else is address-derived
   function automatic logic [23:0] rom_f(input logic [23:0] a);
      if (a == 24'd365) return 24'h332211;
      return {a[7:0] ^ 8'h5A, a[15:8] ^ 8'hC3, a[7:0]};
   endfunction

   // Synchronous ROMs, one clk read latency
   always @(posedge clk) begin
      bus1.rom_data <= rom_f(bus1.rom_addr);
      bus2.rom_data <= rom_f(bus2.rom_addr);
   end

   // Count clk cycles that frame_done is high
   always @(negedge clk) if (bus1.frame_done === 1'b1) fd_cnt++;

   bit          act;
   bit          chk2;
   logic [23:0] e_addr1, e_addr2, p_addr1;
   logic        p_inw1, p_blk, p_hs, p_vs, s_fd;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic reset_model();
      act = 1'b0;
      e_addr1 = '0;
      e_addr2 = '0;
      p_addr1 = '0;
      p_inw1 = 1'b0;
      p_blk = 1'b0;
      p_hs = 1'b1;
      p_vs = 1'b1;
   endtask

   // One pixel: pix_en high for one clk, then one idle clk
   task automatic drive(input int px, input int py, input logic blk);
      bus1.x = px[9:0];         bus2.x = px[9:0];
      bus1.y = py[9:0];         bus2.y = py[9:0];
      bus1.hsync_in = px[2];    bus2.hsync_in = px[2];
      bus1.vsync_in = px[3] ^ py[0];
      bus2.vsync_in = px[3] ^ py[0];
      bus1.blank_b_in = blk;    bus2.blank_b_in = blk;
      bus1.pix_en = 1'b1;       bus2.pix_en = 1'b1;
      @(posedge clk); #1;
      bus1.pix_en = 1'b0;       bus2.pix_en = 1'b0;
      s_fd = bus1.frame_done;
      @(posedge clk); #1;
   endtask

   task automatic step(input int px, input int py, input logic blk, input bit chk_on);
      logic        inw1, inw2, hs, vs;
      logic [23:0] e_rgb;
      hs = px[2];
      vs = px[3] ^ py[0];
      if (px == 0 && py == 0) act = 1'b1;
      inw1 = act && (px < 180) && (py < 180);
      inw2 = act && (px < 360) && (py < 360);
      if (inw1) e_addr1 = 24'(py * 180 + px);
      if (inw2) e_addr2 = 24'((py / 2) * 180 + px / 2);
      e_rgb = (p_inw1 && p_blk) ? rom_f(p_addr1) : 24'h0;
      drive(px, py, blk);
      if (chk_on) begin
         check($sformatf("addr1@%0d,%0d", px, py), bus1.rom_addr, e_addr1);
         if (chk2) check($sformatf("addr2@%0d,%0d", px, py), bus2.rom_addr, e_addr2);
         check($sformatf("rgb@%0d,%0d", px, py), {bus1.b, bus1.g, bus1.r}, e_rgb);
         check($sformatf("fdone@%0d,%0d", px, py), s_fd, inw1 && px == 179 && py == 179);
         check($sformatf("hsync@%0d,%0d", px, py), bus1.hsync, p_hs);
         check($sformatf("vsync@%0d,%0d", px, py), bus1.vsync, p_vs);
         check($sformatf("blank@%0d,%0d", px, py), bus1.blank_b, p_blk);
      end
      p_inw1 = inw1;
      p_blk = blk;
      p_addr1 = e_addr1;
      p_hs = hs;
      p_vs = vs;
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_addr1"}, bus1.rom_addr, 0);
      check({tag, "_addr2"}, bus2.rom_addr, 0);
      check({tag, "_hsync"}, bus1.hsync, 1);
      check({tag, "_vsync"}, bus1.vsync, 1);
      check({tag, "_blank"}, bus1.blank_b, 0);
      check({tag, "_rgb"}, {bus1.b, bus1.g, bus1.r}, 0);
      check({tag, "_fdone"}, bus1.frame_done, 0);
   endtask

   initial begin
      bus1.pix_en = 1'b0; bus2.pix_en = 1'b0;
      bus1.x = '0; bus1.y = '0; bus2.x = '0; bus2.y = '0;
      bus1.hsync_in = 1'b1; bus1.vsync_in = 1'b1; bus1.blank_b_in = 1'b0;
      bus2.hsync_in = 1'b1; bus2.vsync_in = 1'b1; bus2.blank_b_in = 1'b0;
      chk2 = 1'b0;
      reset = 1'b1;
      reset_model();
      repeat (2) @(posedge clk);
      #1;
      check_reset("rst");
      reset = 1'b0;
      @(posedge clk); #1;

      // Before any frame start nothing is fetched
      step(5, 5, 1'b1, 1'b1);

      // Frame A, rows 0..5 across both windows
      chk2 = 1'b1;
      for (int yy = 0; yy < 6; yy++) begin
         for (int xx = 0; xx < 360; xx++) begin
            step(xx, yy, !(xx == 10 && yy == 4), 1'b1);
            if (xx == 5 && yy == 2) check("addr_5_2", bus1.rom_addr, 365);
            if (xx == 6 && yy == 2) begin
               check("r_5_2", bus1.r, 8'h11);
               check("g_5_2", bus1.g, 8'h22);
               check("b_5_2", bus1.b, 8'h33);
            end
            if (yy == 4 && (xx == 2 || xx == 3)) check("s2_addr_row4", bus2.rom_addr, 361);
            if (xx == 3 && yy == 5) check("s2_addr_3_5", bus2.rom_addr, 361);
            if (xx == 200 && yy == 3) check("hold_200_3", bus1.rom_addr, 719);
            if (xx == 201 && yy == 3) check("black_200_3", {bus1.b, bus1.g, bus1.r}, 0);
            if (xx == 11 && yy == 4) check("blank_rgb_10_4", {bus1.b, bus1.g, bus1.r}, 0);
         end
      end
      chk2 = 1'b0;

      // Rest of frame A, window columns only
      for (int yy = 6; yy < 180; yy++) begin
         for (int xx = 0; xx < 180; xx++) begin
            step(xx, yy, 1'b1, yy >= 176);
            if (xx == 179 && yy == 179) begin
               check("fd_pulse", s_fd, 1);
               check("fd_addr", bus1.rom_addr, 32399);
            end
         end
      end
      step(0, 180, 1'b1, 1'b1);
      step(1, 180, 1'b1, 1'b1);
      check("fd_count_A", fd_cnt, 1);

      // Frame B: origin restarts at address 0, then reset mid-frame at (90,90)
      step(0, 0, 1'b1, 1'b1);
      check("origin_addr", bus1.rom_addr, 0);
      step(1, 0, 1'b1, 1'b1);
      step(2, 0, 1'b1, 1'b1);
      step(88, 90, 1'b1, 1'b0);
      step(89, 90, 1'b1, 1'b0);
      step(90, 90, 1'b1, 1'b0);
      reset = 1'b1;
      reset_model();
      @(posedge clk); #1;
      check_reset("midrst");
      @(posedge clk); #1;
      reset = 1'b0;
      for (int xx = 91; xx < 180; xx++) step(xx, 90, 1'b1, 1'b1);
      for (int xx = 0; xx < 180; xx++) begin
         step(xx, 91, 1'b1, 1'b1);
         if (xx == 50) check("post_rst_black", {bus1.b, bus1.g, bus1.r}, 0);
      end

      // Frame C: addressing correct again from the new frame start
      for (int yy = 0; yy < 3; yy++) begin
         for (int xx = 0; xx < 180; xx++) begin
            step(xx, yy, 1'b1, 1'b1);
            if (xx == 0 && yy == 0) check("c_origin_addr", bus1.rom_addr, 0);
            if (xx == 5 && yy == 2) check("c_addr_5_2", bus1.rom_addr, 365);
            if (xx == 6 && yy == 2) check("c_rgb_5_2", {bus1.b, bus1.g, bus1.r}, 24'h332211);
         end
      end
      check("fd_count_total", fd_cnt, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/vga_pixel_fetch.md
VGA_PIXEL_FETCH -- requirements
Module: vga_pixel_fetch

Interface
REQ-001 The block SHALL have parameter LEFT, default 10'd0, meaning image window left column (pixels).
REQ-002 The block SHALL have parameter TOP, default 10'd0, meaning image window top row (pixels).
REQ-003 The block SHALL have parameter IMG_W, default 180, meaning source image width in ROM words.
REQ-004 The block SHALL have parameter IMG_H, default 180, meaning source image height in ROM rows.
REQ-005 The block SHALL have parameter SCALE, default 1, meaning pixel replication factor; legal values are only 1 and 2.
REQ-006 clk  in  1  system clock; the block SHALL use one clock only, and all state SHALL update on its rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 pix_en  in  1  pixel-rate enable; it SHALL be asserted for at most one clk cycle in any two consecutive clk cycles.
REQ-009 x, y  in  10 each  raster position from the timing controller, valid while pix_en=1.
REQ-010 hsync_in, vsync_in, blank_b_in  in  1 each  timing controller syncs (active low) and blank (active high = visible).
REQ-011 rom_addr  out  24  image ROM word address; it SHALL be registered.
REQ-012 rom_data  in  24  ROM read data; the ROM is synchronous with 1 clk read latency.
REQ-013 hsync, vsync, blank_b  out  1 each  syncs and blank delayed to align with rgb.
REQ-014 r, g, b  out  8 each  pixel colour.
REQ-015 frame_done  out  1  one-clk pulse when the last image address of a frame is issued.

Function
REQ-016 The pipeline SHALL advance only on clk edges where pix_en=1; on all other edges, all registers SHALL hold.
REQ-017 Stage 1 SHALL register rom_addr, in_win, and the three timing inputs; stage 2 SHALL register rgb and the delayed timing signals, giving exactly 2 pix_en latency from x/y to outputs.
REQ-018 in_win SHALL be true iff LEFT<=x<LEFT+IMG_W*SCALE, TOP<=y<TOP+IMG_H*SCALE, and state==ACTIVE.
REQ-019 Address generation SHALL use counters only (no multiplier), and rom_addr SHALL equal row_base+col, where row_base is ((y-TOP)/SCALE)*IMG_W and col is (x-LEFT)/SCALE.
REQ-020 The xrep counter SHALL increment on each in-window pixel; col SHALL increment when xrep==SCALE-1, wrapping xrep to 0.
REQ-021 col and xrep SHALL clear when x==LEFT.
REQ-022 At the last in-window pixel of a line, yrep SHALL increment; when yrep==SCALE-1, row_base SHALL increase by IMG_W and yrep SHALL clear.
REQ-023 row_base and yrep SHALL clear when x==0 and y==0 (frame start).
REQ-024 When in_win is false, rom_addr SHALL hold its previous value.
REQ-025 State machine: WAIT_FRAME SHALL move to ACTIVE at a pix_en with x==0 and y==0; ACTIVE SHALL remain ACTIVE; the only exit to WAIT_FRAME SHALL be reset.
REQ-026 Stage 2 SHALL set r=rom_data[7:0], g=rom_data[15:8], b=rom_data[23:16] when stage-1 in_win=1 and blank_b=1; otherwise r, g and b SHALL be 8'h00.
REQ-027 frame_done SHALL assert for the single clk edge that issues address IMG_W*IMG_H-1 on the final replicated row and column.
REQ-028 When x==0 and y==0 coincide with an in-window pixel (LEFT=TOP=0), the frame-start clear SHALL take priority, and the pixel SHALL use address 0.

Reset
REQ-029 While reset=1: state=WAIT_FRAME; rom_addr=0; all counters=0; hsync=1; vsync=1; blank_b=0; r=g=b=0; frame_done=0.
REQ-030 After a mid-frame reset, outputs SHALL be black until the next frame start, and addressing SHALL be correct from that frame onward.

Verification
REQ-031 Defaults, after a frame start: drive (x=5, y=2) -> rom_addr=365 one pix_en later; with rom_data=24'h332211, two pix_en later r=8'h11, g=8'h22, b=8'h33.
REQ-032 SCALE=2: (x=3, y=5) -> rom_addr=361; (x=2, y=4) and (x=3, y=4) -> both rom_addr=361.
REQ-033 Defaults: (x=200, y=10) or blank_b_in=0 -> r=g=b=0, and rom_addr holds its last value.
REQ-034 Full 800x525 raster with pix_en every other clk -> frame_done pulses exactly once per frame, at rom_addr=32399.
REQ-035 Assert reset at (x=90, y=90), release, and continue the raster -> rgb=0 until x=0, y=0; the next frame has correct addresses starting from 0.
REQ-036 Toggle hsync_in and vsync_in -> hsync and vsync match them, delayed by exactly 2 pix_en.
